// File: rtl/rgmii_frame_tx_if.sv
// Control, payload stream and RGMII transmit signals of one frame transmitter.
interface rgmii_frame_tx_if;
   logic        start;
   logic [10:0] len;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        busy;
   logic        done;
   logic        underrun;
   logic        txctl;
   logic [3:0]  txd;

   modport master (
      output start, len, s_data, s_valid,
      input  s_ready, busy, done, underrun, txctl, txd
   );

   modport slave (
      input  start, len, s_data, s_valid,
      output s_ready, busy, done, underrun, txctl, txd
   );
endinterface

// File: rtl/rgmii_frame_tx.sv
// Ethernet frame transmitter on RGMII: preamble, SFD, fixed header, stream or
// pattern payload, zero padding, CRC-32 FCS and an enforced inter-frame gap.
module rgmii_frame_tx #(
   parameter logic [47:0] DST_MAC      = 48'h1919_08bf_b8da,
   parameter logic [47:0] SRC_MAC      = 48'h8800_0088_dab8,
   parameter logic [15:0] ETHERTYPE    = 16'hbf08,
   parameter int unsigned MAX_PAYLOAD  = 1500,
   parameter int unsigned IFG          = 12,
   parameter int unsigned PAYLOAD_MODE = 0
) (
   input logic             clk125_i,
   input logic             rst_i,
   rgmii_frame_tx_if.slave tx_if
);

   localparam int unsigned MIN_PAY  = 46;
   localparam int unsigned HDR_LEN  = 14;
   localparam int unsigned PRE_LEN  = 7;
   localparam int unsigned FCS_LEN  = 4;
   localparam int unsigned SPAN_A   = (MAX_PAYLOAD > MIN_PAY) ? MAX_PAYLOAD : MIN_PAY;
   localparam int unsigned CNT_SPAN = (SPAN_A > IFG) ? SPAN_A : IFG;
   localparam int unsigned CW       = $clog2(CNT_SPAN + 1);

   localparam logic [CW-1:0]  MAX_L = CW'(MAX_PAYLOAD);
   localparam logic [111:0]   HDR   = {DST_MAC, SRC_MAC, ETHERTYPE};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_SFD  = 3'd2;
   localparam logic [2:0] S_HDR  = 3'd3;
   localparam logic [2:0] S_PAY  = 3'd4;
   localparam logic [2:0] S_PAD  = 3'd5;
   localparam logic [2:0] S_FCS  = 3'd6;
   localparam logic [2:0] S_GAP  = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] len_q, len_d;
   logic [31:0]   crc_q, crc_d;
   logic          err_q, err_d;
   logic [7:0]    txd_q, txd_d;
   logic          txctl_q, txctl_d;
   logic          s_ready_q, s_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          underrun_q, underrun_d;

   logic [CW-1:0] len_clamp_c;
   logic [7:0]    hdr_byte_c;
   logic [7:0]    fcs_byte_c;
   logic          pad_last_c;
   logic          crc_en_c;

   // Reflected CRC-32, one byte LSB first.
   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int b = 0; b < 8; b++) begin
         c = (c[0] ^ data[b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   assign len_clamp_c = (32'(tx_if.len) > MAX_PAYLOAD) ? MAX_L : CW'(tx_if.len);
   assign pad_last_c  = (cnt_q + len_q) == CW'(MIN_PAY - 1);

   always_comb begin
      hdr_byte_c = 8'h00;
      for (int i = 0; i < 14; i++) begin
         if (cnt_q == CW'(i)) hdr_byte_c = HDR[8*(13-i) +: 8];
      end
   end

   // An underrun anywhere in the frame forces a bad FCS.
   always_comb begin
      case (cnt_q[1:0])
         2'd0:    fcs_byte_c = crc_q[7:0];
         2'd1:    fcs_byte_c = crc_q[15:8];
         2'd2:    fcs_byte_c = crc_q[23:16];
         default: fcs_byte_c = crc_q[31:24];
      endcase
      fcs_byte_c = ~fcs_byte_c ^ {8{err_q}};
   end

   always_ff @(posedge clk125_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         crc_q      <= 32'hFFFF_FFFF;
         err_q      <= 1'b0;
         txd_q      <= 8'h00;
         txctl_q    <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         crc_q      <= crc_d;
         err_q      <= err_d;
         txd_q      <= txd_d;
         txctl_q    <= txctl_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   // state_q/cnt_q name the byte that is registered onto txd at the next edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CW'(1);
      len_d      = len_q;
      crc_d      = crc_q;
      err_d      = err_q;
      txd_d      = 8'h00;
      txctl_d    = 1'b1;
      underrun_d = 1'b0;
      crc_en_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            txctl_d = 1'b0;
            cnt_d   = '0;
            err_d   = 1'b0;
            if (tx_if.start) begin
               state_d = S_PRE;
               len_d   = len_clamp_c;
            end
         end
         S_PRE: begin
            txd_d = 8'h55;
            if (cnt_q == CW'(PRE_LEN - 1)) begin
               state_d = S_SFD;
               cnt_d   = '0;
            end
         end
         S_SFD: begin
            txd_d   = 8'hD5;
            crc_d   = 32'hFFFF_FFFF;
            state_d = S_HDR;
            cnt_d   = '0;
         end
         S_HDR: begin
            txd_d    = hdr_byte_c;
            crc_en_c = 1'b1;
            if (cnt_q == CW'(HDR_LEN - 1)) begin
               state_d = (len_q == '0) ? S_PAD : S_PAY;
               cnt_d   = '0;
            end
         end
         S_PAY: begin
            crc_en_c = 1'b1;
            if (PAYLOAD_MODE != 0) begin
               txd_d = 8'(cnt_q);
            end else if (tx_if.s_valid) begin
               txd_d = tx_if.s_data;
            end else begin
               underrun_d = 1'b1;
               err_d      = 1'b1;
            end
            if (cnt_q == len_q - CW'(1)) begin
               state_d = (len_q < CW'(MIN_PAY)) ? S_PAD : S_FCS;
               cnt_d   = '0;
            end
         end
         S_PAD: begin
            crc_en_c = 1'b1;
            if (pad_last_c) begin
               state_d = S_FCS;
               cnt_d   = '0;
            end
         end
         S_FCS: begin
            txd_d = fcs_byte_c;
            if (cnt_q == CW'(FCS_LEN - 1)) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            txctl_d = 1'b0;
            if (cnt_q == CW'(IFG - 1)) begin
               cnt_d = '0;
               if (tx_if.start) begin
                  state_d = S_PRE;
                  len_d   = len_clamp_c;
                  err_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            txctl_d = 1'b0;
            cnt_d   = '0;
         end
      endcase

      if (crc_en_c) crc_d = crc_step(crc_q, txd_d);

      s_ready_d = (state_d == S_PAY) && (PAYLOAD_MODE == 0);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_GAP) && (cnt_d == CW'(IFG - 1));
   end

   assign tx_if.s_ready  = s_ready_q;
   assign tx_if.busy     = busy_q;
   assign tx_if.done     = done_q;
   assign tx_if.underrun = underrun_q;
   assign tx_if.txctl    = txctl_q;
   assign tx_if.txd      = clk125_i ? txd_q[3:0] : txd_q[7:4];

endmodule
